// File: rtl/mem_read_arbiter_pkg.sv
// Shared types for the fetch/load memory read arbiter.
// Owner encodings, in-flight tag and bus widths.
package mem_read_arbiter_pkg;

  localparam int ADDR_W = 61;
  localparam int DATA_W = 64;

  localparam logic OWNER_FETCH = 1'b0;
  localparam logic OWNER_LOAD  = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;

endpackage

// File: rtl/mem_tag_pipe.sv
// DEPTH-stage tag shift register tracking in-flight reads.
// Ports: clk, rst, tagIn (stage 0 load), tagLast (oldest stage).
module mem_tag_pipe
  import mem_read_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tagIn,
  output tag_t tagLast
);

  tag_t stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        stage[i] <= '0;
    end else begin
      stage[0] <= tagIn;
      for (int i = 1; i < DEPTH; i++)
        stage[i] <= stage[i-1];
    end
  end

  assign tagLast = stage[DEPTH-1];

endmodule

// File: rtl/mem_read_arbiter.sv
// Shares one pipelined memory read port between fetch and load.
// Ports: f_req/l_req (valid/addr/ready), f_rsp/l_rsp (valid/data),
//   mem_rd (valid/addr), mem_rsp (valid/data), grant counters,
//   sticky proto_err.
module mem_read_arbiter
  import mem_read_arbiter_pkg::*;
#(
  parameter int MEM_LAT      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req_valid,
  input  logic [0:ADDR_W-1] f_req_addr,
  output logic              f_req_ready,
  output logic              f_rsp_valid,
  output logic [0:DATA_W-1] f_rsp_data,
  input  logic              l_req_valid,
  input  logic [0:ADDR_W-1] l_req_addr,
  output logic              l_req_ready,
  output logic              l_rsp_valid,
  output logic [0:DATA_W-1] l_rsp_data,
  output logic              mem_rd_valid,
  output logic [0:ADDR_W-1] mem_rd_addr,
  input  logic              mem_rsp_valid,
  input  logic [0:DATA_W-1] mem_rsp_data,
  output logic [0:31]       fetch_grants,
  output logic [0:31]       load_grants,
  output logic              proto_err
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  localparam logic [3:0] BLANK = 4'(MEM_LAT);

  logic       fGrant;
  logic       lGrant;
  logic       fRet;
  logic       lRet;
  logic [3:0] starveCnt;
  logic [3:0] blankCnt;
  logic [0:31] fetchCnt;
  logic [0:31] loadCnt;
  tag_t       tagIn;
  tag_t       tagLast;

  always_comb begin
    fGrant = f_req_valid &&
             (!l_req_valid || starveCnt == LIMIT);
    lGrant = l_req_valid && !fGrant;
  end

  always_comb begin
    mem_rd_addr = '0;
    unique case (1'b1)
      fGrant:  mem_rd_addr = f_req_addr;
      lGrant:  mem_rd_addr = l_req_addr;
      default: mem_rd_addr = '0;
    endcase
  end

  assign f_req_ready  = fGrant;
  assign l_req_ready  = lGrant;
  assign mem_rd_valid = fGrant | lGrant;
  assign fetch_grants = fetchCnt;
  assign load_grants  = loadCnt;

  assign tagIn.valid = mem_rd_valid;
  assign tagIn.owner = lGrant ? OWNER_LOAD : OWNER_FETCH;

  mem_tag_pipe #(
    .DEPTH (MEM_LAT)
  ) u_tags (
    .clk     (clk),
    .rst     (rst),
    .tagIn   (tagIn),
    .tagLast (tagLast)
  );

  assign fRet = tagLast.valid && tagLast.owner == OWNER_FETCH;
  assign lRet = tagLast.valid && tagLast.owner == OWNER_LOAD;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      starveCnt <= '0;
    else if (!f_req_valid || fGrant)
      starveCnt <= '0;
    else if (starveCnt != LIMIT)
      starveCnt <= starveCnt + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetchCnt <= '0;
      loadCnt  <= '0;
    end else begin
      if (fGrant) fetchCnt <= fetchCnt + 32'd1;
      if (lGrant) loadCnt  <= loadCnt + 32'd1;
    end
  end

  // Reads dropped by a reset may still come back from memory;
  // ignore mismatches until the tag pipe has refilled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blankCnt  <= BLANK;
      proto_err <= 1'b0;
    end else begin
      if (blankCnt != 4'd0)
        blankCnt <= blankCnt - 4'd1;
      else if (mem_rsp_valid != tagLast.valid)
        proto_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_rsp_valid <= 1'b0;
      l_rsp_valid <= 1'b0;
      f_rsp_data  <= '0;
      l_rsp_data  <= '0;
    end else begin
      f_rsp_valid <= fRet;
      l_rsp_valid <= lRet;
      if (fRet) f_rsp_data <= mem_rsp_data;
      if (lRet) l_rsp_data <= mem_rsp_data;
    end
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter with a fixed-latency
// memory model and an in-order response scoreboard.
module tb_mem_read_arbiter;

  localparam int MEM_LAT      = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req_valid;
  logic [0:60] f_req_addr;
  logic        f_req_ready;
  logic        f_rsp_valid;
  logic [0:63] f_rsp_data;
  logic        l_req_valid;
  logic [0:60] l_req_addr;
  logic        l_req_ready;
  logic        l_rsp_valid;
  logic [0:63] l_rsp_data;
  logic        mem_rd_valid;
  logic [0:60] mem_rd_addr;
  logic        mem_rsp_valid;
  logic [0:63] mem_rsp_data;
  logic [0:31] fetch_grants;
  logic [0:31] load_grants;
  logic        proto_err;

  mem_read_arbiter #(
    .MEM_LAT      (MEM_LAT),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .f_req_valid   (f_req_valid),
    .f_req_addr    (f_req_addr),
    .f_req_ready   (f_req_ready),
    .f_rsp_valid   (f_rsp_valid),
    .f_rsp_data    (f_rsp_data),
    .l_req_valid   (l_req_valid),
    .l_req_addr    (l_req_addr),
    .l_req_ready   (l_req_ready),
    .l_rsp_valid   (l_rsp_valid),
    .l_rsp_data    (l_rsp_data),
    .mem_rd_valid  (mem_rd_valid),
    .mem_rd_addr   (mem_rd_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .fetch_grants  (fetch_grants),
    .load_grants   (load_grants),
    .proto_err     (proto_err)
  );

  always #5 clk = ~clk;

  function automatic logic [0:63] memData(input logic [0:60] a);
    return {a, 3'b011} ^ 64'hC3A5_0F1E_7D29_B486;
  endfunction

  // memory model: not reset, answers MEM_LAT cycles after issue
  logic        p0v = 1'b0;
  logic        p1v = 1'b0;
  logic [0:60] p0a = '0;
  logic [0:60] p1a = '0;
  logic        inject = 1'b0;

  always @(posedge clk) begin
    p0v <= mem_rd_valid;
    p0a <= mem_rd_addr;
    p1v <= p0v;
    p1a <= p0a;
  end

  assign mem_rsp_valid = p1v | inject;
  assign mem_rsp_data  = p1v ? memData(p1a) : 64'h0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit monOn = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    int          due;
    logic        owner;
    logic [0:63] data;
  } exp_t;

  exp_t q[$];
  logic [0:63] lastF = '0;
  logic [0:63] lastL = '0;
  logic [31:0] expFCnt = '0;
  logic [31:0] expLCnt = '0;

  always @(negedge clk) begin
    logic ef;
    logic el;
    exp_t e;
    #1;
    if (monOn) begin
      ef = 1'b0;
      el = 1'b0;
      if (rst) begin
        q.delete();
        lastF = '0;
        lastL = '0;
      end else if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        if (e.owner) begin
          el = 1'b1;
          lastL = e.data;
        end else begin
          ef = 1'b1;
          lastF = e.data;
        end
      end
      chk("f_rsp_valid", 64'(f_rsp_valid), 64'(ef));
      chk("l_rsp_valid", 64'(l_rsp_valid), 64'(el));
      chk("f_rsp_data", f_rsp_data, lastF);
      chk("l_rsp_data", l_rsp_data, lastL);
    end
  end

  task automatic drive(input logic fv, input logic [0:60] fa,
                       input logic lv, input logic [0:60] la,
                       input logic efr, input logic elr,
                       input logic [0:60] ema, input bit track);
    @(negedge clk);
    f_req_valid = fv;
    f_req_addr  = fa;
    l_req_valid = lv;
    l_req_addr  = la;
    #1;
    chk("f_req_ready", 64'(f_req_ready), 64'(efr));
    chk("l_req_ready", 64'(l_req_ready), 64'(elr));
    chk("mem_rd_valid", 64'(mem_rd_valid), 64'(efr | elr));
    chk("mem_rd_addr", 64'(mem_rd_addr), 64'(ema));
    if (track && (efr || elr)) begin
      q.push_back('{due: cyc + MEM_LAT + 1, owner: elr,
                    data: memData(ema)});
      if (elr) expLCnt = expLCnt + 32'd1;
      else     expFCnt = expFCnt + 32'd1;
    end
  endtask

  task automatic idle(input int n);
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic        fv;
    logic [0:60] fa;
    logic        lv;
    logic [0:60] la;
    logic        fr;
    logic        lr;
    logic [0:60] ma;
  } vec_t;

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{1'b0, 61'h00, 1'b0, 61'h00, 1'b0, 1'b0, 61'h00};
    vecs[1]  = '{1'b1, 61'h40, 1'b0, 61'h00, 1'b1, 1'b0, 61'h40};
    vecs[2]  = '{1'b0, 61'h00, 1'b1, 61'h50, 1'b0, 1'b1, 61'h50};
    vecs[3]  = '{1'b1, 61'h41, 1'b1, 61'h51, 1'b0, 1'b1, 61'h51};
    vecs[4]  = '{1'b0, 61'h00, 1'b1, 61'h52, 1'b0, 1'b1, 61'h52};
    vecs[5]  = '{1'b1, 61'h42, 1'b1, 61'h53, 1'b0, 1'b1, 61'h53};
    vecs[6]  = '{1'b1, 61'h42, 1'b1, 61'h54, 1'b0, 1'b1, 61'h54};
    vecs[7]  = '{1'b1, 61'h42, 1'b1, 61'h55, 1'b0, 1'b1, 61'h55};
    vecs[8]  = '{1'b1, 61'h42, 1'b1, 61'h56, 1'b0, 1'b1, 61'h56};
    vecs[9]  = '{1'b1, 61'h42, 1'b1, 61'h57, 1'b1, 1'b0, 61'h42};
    vecs[10] = '{1'b1, 61'h43, 1'b1, 61'h57, 1'b0, 1'b1, 61'h57};
    vecs[11] = '{1'b1, 61'h43, 1'b1, 61'h58, 1'b0, 1'b1, 61'h58};
    vecs[12] = '{1'b1, 61'h43, 1'b1, 61'h59, 1'b0, 1'b1, 61'h59};
    vecs[13] = '{1'b1, 61'h43, 1'b1, 61'h5A, 1'b0, 1'b1, 61'h5A};
    vecs[14] = '{1'b1, 61'h43, 1'b1, 61'h5B, 1'b1, 1'b0, 61'h43};
    vecs[15] = '{1'b0, 61'h00, 1'b0, 61'h00, 1'b0, 1'b0, 61'h00};

    rst = 1'b1;
    f_req_valid = 1'b0;
    f_req_addr  = '0;
    l_req_valid = 1'b0;
    l_req_addr  = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_f_req_ready", 64'(f_req_ready), 64'd0);
    chk("rst_mem_rd_valid", 64'(mem_rd_valid), 64'd0);
    chk("rst_f_rsp_valid", 64'(f_rsp_valid), 64'd0);
    chk("rst_l_rsp_valid", 64'(l_rsp_valid), 64'd0);
    chk("rst_f_rsp_data", f_rsp_data, 64'd0);
    chk("rst_l_rsp_data", l_rsp_data, 64'd0);
    chk("rst_fetch_grants", 64'(fetch_grants), 64'd0);
    chk("rst_load_grants", 64'(load_grants), 64'd0);
    chk("rst_proto_err", 64'(proto_err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    monOn = 1'b1;

    // fetch only: response pulses MEM_LAT+1 cycles later
    drive(1'b1, 61'h10, 1'b0, '0, 1'b1, 1'b0, 61'h10, 1'b1);
    idle(4);
    chk("fetch_only_grants", 64'(fetch_grants), 64'd1);

    // priority / starvation table, responses scoreboarded
    for (int i = 0; i < 16; i++)
      drive(vecs[i].fv, vecs[i].fa, vecs[i].lv, vecs[i].la,
            vecs[i].fr, vecs[i].lr, vecs[i].ma, 1'b1);
    idle(5);
    chk("table_fetch_grants", 64'(fetch_grants), 64'(expFCnt));
    chk("table_load_grants", 64'(load_grants), 64'(expLCnt));
    chk("table_drained", 64'(q.size()), 64'd0);

    // reset while a fetch is in flight
    drive(1'b1, 61'h30, 1'b0, '0, 1'b1, 1'b0, 61'h30, 1'b0);
    @(negedge clk);
    f_req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expFCnt = '0;
    expLCnt = '0;
    repeat (6) @(negedge clk);
    #1;
    chk("midrst_fetch_grants", 64'(fetch_grants), 64'd0);
    chk("midrst_load_grants", 64'(load_grants), 64'd0);
    chk("midrst_proto_err", 64'(proto_err), 64'd0);

    // back-to-back loads
    drive(1'b0, '0, 1'b1, 61'h20, 1'b0, 1'b1, 61'h20, 1'b1);
    drive(1'b0, '0, 1'b1, 61'h21, 1'b0, 1'b1, 61'h21, 1'b1);
    drive(1'b0, '0, 1'b1, 61'h22, 1'b0, 1'b1, 61'h22, 1'b1);
    idle(5);
    chk("b2b_load_grants", 64'(load_grants), 64'd3);
    chk("b2b_proto_err", 64'(proto_err), 64'd0);

    // unexpected memory response with an empty pipe
    @(negedge clk);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    #1;
    chk("proto_err_set", 64'(proto_err), 64'd1);
    repeat (4) @(negedge clk);
    #1;
    chk("proto_err_sticky", 64'(proto_err), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("proto_err_clear", 64'(proto_err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // fetch counter wrap
    force dut.fetchCnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.fetchCnt;
    drive(1'b1, 61'h60, 1'b0, '0, 1'b1, 1'b0, 61'h60, 1'b1);
    idle(4);
    chk("wrap_fetch_grants", 64'(fetch_grants), 64'd0);
    chk("wrap_load_grants", 64'(load_grants), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_read_arbiter.md
Name: mem_read_arbiter

Overview:
- Shares one 64-bit doubleword memory read port between the core's two read requesters: instruction fetch (requester 0) and data load, ld/ldu (requester 1).
- Replaces the current dual-port memory hookup. It sits between the core and a single-port pipelined memory with a fixed read latency.
- Arbitrates each cycle and tracks in-flight reads with a tag pipeline. Routes each returned doubleword to its owner and prevents fetch starvation.

Parameters:
- MEM_LAT, 2, fixed memory read latency in cycles, legal range 1..8.
- STARVE_LIMIT, 4, consecutive fetch losses before fetch is forced to win, legal range 1..15.

Ports:
- clk  input  1  core clock, all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- f_req_valid  input  1  fetch request valid.
- f_req_addr  input  [0:60]  fetch doubleword address.
- f_req_ready  output  1  fetch request accepted this cycle.
- f_rsp_valid  output  1  fetch data valid, one-cycle pulse.
- f_rsp_data  output  [0:63]  fetch doubleword.
- l_req_valid  input  1  load request valid.
- l_req_addr  input  [0:60]  load doubleword address.
- l_req_ready  output  1  load request accepted this cycle.
- l_rsp_valid  output  1  load data valid, one-cycle pulse.
- l_rsp_data  output  [0:63]  load doubleword.
- mem_rd_valid  output  1  read issued to memory.
- mem_rd_addr  output  [0:60]  read address.
- mem_rsp_valid  input  1  memory data valid, expected exactly MEM_LAT cycles after issue.
- mem_rsp_data  input  [0:63]  memory read data.
- fetch_grants  output  [0:31]  count of accepted fetches, wraps.
- load_grants  output  [0:31]  count of accepted loads, wraps.
- proto_err  output  1  sticky protocol error flag.

Behaviour:
- Reset (async, any time): tag pipeline cleared, starvation counter 0, both grant counters 0, proto_err 0. All rsp_valid outputs are 0. rsp_data outputs are 0.
- Reset mid-operation: in-flight reads are discarded. A mem_rsp_valid arriving after reset deasserts does not produce an rsp pulse and does not set proto_err during the first MEM_LAT cycles after reset.
- Grant is combinational in the same cycle. At most one of f_req_ready and l_req_ready is high. Ready is high only when the matching valid is high.
- A transfer occurs on valid and ready at posedge. mem_rd_valid equals OR of the two grants. mem_rd_addr is the granted address, or 0 when idle.
- Priority:
  - Load wins by default, so data hazards resolve first.
  - When the starvation count equals STARVE_LIMIT, fetch wins instead.
- Starvation counter, 4-bit:
  - Increments when f_req_valid is high and fetch is not granted.
  - Clears when fetch is granted or f_req_valid is low.
  - Saturates at STARVE_LIMIT.
- Tag pipeline:
  - MEM_LAT stages, each holding {valid, owner}. It shifts every cycle.
  - Stage 0 loads {mem_rd_valid, owner granted} at posedge.
  - The last stage is the expected response for the current cycle.
- Response routing:
  - When the last stage is valid, mem_rsp_data is registered into the owner's rsp_data and rsp_valid pulses on the following cycle.
  - Total request-to-response latency is MEM_LAT+1 cycles.
  - The non-owner rsp_valid stays 0, and its rsp_data holds its previous value.
- proto_err sets when mem_rsp_valid differs from the last-stage valid. Only reset clears it.
- Back-to-back issue is allowed every cycle. Requests are not buffered: an ungranted requester must hold valid and address until ready.
- Responses are returned in issue order. A pipelined memory guarantees this, so no reorder buffer exists.
- Grant counters increment by 1 on each accepted transfer and wrap from 0xFFFFFFFF to 0.

Decomposition:
- Shared package holds:
  - OWNER_FETCH = 0 and OWNER_LOAD = 1.
  - A tag typedef {valid, owner}.
  - The address width 61 and data width 64 constants.
- One sub-module is natural: mem_tag_pipe, a parameterized MEM_LAT-deep shift register of tags with a reset-clear and a last-stage output.

Test Plan:
- Fetch only: f_req_valid=1 with f_req_addr=0x10 for 1 cycle, MEM_LAT=2. Expect f_req_ready=1 and mem_rd_addr=0x10. f_rsp_valid pulses at cycle 3 with the memory data, and fetch_grants=1.
- Contention: both valid every cycle, STARVE_LIMIT=4. Grant sequence is L,L,L,L,F,L,L,L,L,F. Responses are routed in the same order, and there is no cycle with both readies high.
- Back-to-back: loads to 0x20, 0x21 and 0x22 on consecutive cycles. l_rsp_valid is high for 3 consecutive cycles with data in issue order, and load_grants=3.
- Reset mid-flight: issue a fetch, then assert rst for 1 cycle in cycle 1. No f_rsp_valid occurs, counters read 0, and proto_err stays 0.
- Protocol error: memory drives mem_rsp_valid=1 with an empty pipeline. proto_err goes to 1 and stays 1 until rst.
- Counter wrap: force fetch_grants to 0xFFFFFFFF, then do 1 fetch. The counter reads 0x00000000.
